debug_reg_access: RTL and testbench

Debug-host access port for the integer register file of the 5-stage `datapath`. It accepts single read/write requests from a debug host over a valid/ready channel. It halts the pipeline through a halt request/acknowledge handshake, then reads or writes one GPR through a dedicated debug port on the register file. The result is returned on a valid/ready response channel. It is the driving end of register-file debug traffic; the existing debug benches only observe that traffic.

---
 rtl/dbg_pkg.sv | 7 +
 rtl/debug_reg_access.sv | 104 ++++++++++
 tb/tb_debug_reg_access.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encoding and widths for the debug register access port
package dbg_pkg;
  localparam int DBG_ADDR_W = 5;
  localparam int DBG_DATA_W = 32;
  localparam int DBG_TIMEOUT_DEFAULT = 64;
  typedef enum logic [1:0] {DBG_IDLE, DBG_HALT, DBG_ACCESS, DBG_RESP} dbg_state_t;
endpackage

// File: rtl/debug_reg_access.sv
// debug_reg_access: halts the core and performs one debug GPR read/write (halt timeout under DBG_HALT_TIMEOUT_EN)
module debug_reg_access
  import dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBG_TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DBG_ADDR_W-1:0] req_addr,
  input  logic [DBG_DATA_W-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DBG_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  halt_req,
  input  logic                  halt_ack,
  output logic                  rf_we,
  output logic [DBG_ADDR_W-1:0] rf_waddr,
  output logic [DBG_DATA_W-1:0] rf_wdata,
  output logic [DBG_ADDR_W-1:0] rf_raddr,
  input  logic [DBG_DATA_W-1:0] rf_rdata,
  output logic                  busy
);
  dbg_state_t state_q;
  logic write_q, halt_req_q, rf_we_q, resp_valid_q, resp_err_q;
  logic [DBG_ADDR_W-1:0] addr_q;
  logic [DBG_DATA_W-1:0] wdata_q, resp_rdata_q;
  logic timeout_hit;
`ifdef DBG_HALT_TIMEOUT_EN
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 16'd1;
  assign timeout_hit = !halt_ack && cnt_d == TO;
  // Count HALT cycles without ack; held at zero outside HALT so each entry starts fresh
  always_ff @(posedge clock) begin
    if (reset || state_q != DBG_HALT) cnt_q <= '0;
    else if (!halt_ack) cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif
  // Sequencer: accept, halt, one-cycle register access, hold response until taken
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DBG_IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      halt_req_q <= 1'b0;
      rf_we_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        DBG_IDLE: if (req_valid) begin
          write_q <= req_write;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          halt_req_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_err_q <= 1'b0;
          state_q <= DBG_HALT;
        end
        DBG_HALT: if (halt_ack) begin
          rf_we_q <= write_q && addr_q != '0;
          state_q <= DBG_ACCESS;
        end else if (timeout_hit) begin
          resp_err_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state_q <= DBG_RESP;
        end
        DBG_ACCESS: begin
          resp_rdata_q <= (write_q || addr_q == '0) ? '0 : rf_rdata;
          resp_valid_q <= 1'b1;
          state_q <= DBG_RESP;
        end
        DBG_RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          halt_req_q <= 1'b0;
          state_q <= DBG_IDLE;
        end
        default: state_q <= DBG_IDLE;
      endcase
    end
  end
  assign req_ready = state_q == DBG_IDLE;
  assign busy = state_q != DBG_IDLE;
  assign halt_req = halt_req_q;
  assign rf_we = rf_we_q;
  assign rf_waddr = addr_q;
  assign rf_wdata = wdata_q;
  assign rf_raddr = addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err = resp_err_q;
endmodule

// File: tb/tb_debug_reg_access.sv
// tb_debug_reg_access: table-driven scoreboard bench for debug_reg_access with a register-file model
module tb_debug_reg_access;
  localparam int T = 4;
`ifdef DBG_HALT_TIMEOUT_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 5;
`endif
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 0, halt_ack = 0, force_ones = 0;
  logic [4:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, halt_req, rf_we, busy;
  logic [31:0] resp_rdata, rf_wdata, rf_rdata;
  logic [4:0] rf_waddr, rf_raddr;
  int compared, mismatched, cyc;

  debug_reg_access #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .halt_req(halt_req), .halt_ack(halt_ack), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] rf [32];
  bit rf_ok;
  always @(posedge clock) begin
    if (!rf_ok) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 3) ? 32'h2A : (32'hA500_0000 | 32'(i));
      rf_ok <= 1'b1;
    end else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = force_ones ? 32'hFFFF_FFFF : rf[rf_raddr];

  typedef struct {
    bit wr; logic [4:0] a; logic [31:0] wd; int d; int r; bit f;
    logic [31:0] er; bit ee; int lat;
  } vec_t;
  typedef struct { logic [31:0] rdata; bit err; int cyc; } exp_t;
  typedef struct { logic [4:0] a; logic [31:0] d; int cyc; } wexp_t;
  vec_t tbl[$];
  exp_t exp_q[$];
  wexp_t wexp_q[$];
  exp_t e;
  wexp_t w;
  bit seen;
  logic [31:0] held_rdata;
  logic held_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response and register-file write monitor
  always @(negedge clock) begin
    if (reset) seen = 0;
    else begin
      if (resp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        chk("halt_req_in_resp", halt_req, 1);
        if (!seen) begin
          seen = 1;
          chk("resp_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", resp_err, e.err);
            chk("resp_cycle", cyc, e.cyc);
          end
          held_rdata = resp_rdata;
          held_err = resp_err;
        end else begin
          chk("rdata_stable", resp_rdata, held_rdata);
          chk("err_stable", resp_err, held_err);
        end
        if (resp_ready) seen = 0;
      end
      if (rf_we) begin
        chk("rf_we_halted", halt_ack, 1);
        chk("rf_we_expected", 32'(wexp_q.size() != 0), 1);
        if (wexp_q.size() != 0) begin
          w = wexp_q.pop_front();
          chk("rf_waddr", rf_waddr, w.a);
          chk("rf_wdata", rf_wdata, w.d);
          chk("rf_we_cycle", cyc, w.cyc);
        end
      end
    end
  end

  task automatic run(input vec_t v);
    int n, k, c;
    bit hs;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
    chk("req_ready_before", req_ready, 1);
    force_ones = v.f;
    resp_ready = 0;
    halt_ack = 0;
    req_valid = 1; req_write = v.wr; req_addr = v.a; req_wdata = v.wd;
    @(posedge clock); #1;
    req_valid = 0;
    exp_q.push_back('{v.er, v.ee, cyc - 1 + v.lat});
    if (v.wr && v.a != 0 && !v.ee) wexp_q.push_back('{v.a, v.wd, cyc + 1 + v.d});
    k = 0;
    hs = 0;
    for (c = 1; c < 200 && !hs; c++) begin
      halt_ack = c > v.d;
      if (resp_valid) begin resp_ready = k >= v.r; k++; end
      req_valid = v.r > 0;
      hs = resp_valid && resp_ready;
      @(posedge clock); #1;
    end
    req_valid = 0; resp_ready = 0; halt_ack = 0; force_ones = 0;
    chk("handshake_seen", hs, 1);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_halt_req", halt_req, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3});
    tbl.push_back('{0, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 3});
    tbl.push_back('{0, 3, 0, 0, 0, 0, 32'h2A, 0, 3});
    tbl.push_back('{1, 0, 32'h1234, 0, 0, 0, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 3});
    tbl.push_back('{0, 7, 0, DLY, 3, 0, 32'hA500_0007, 0, 3 + DLY});
    tbl.push_back('{1, 31, 32'h0F0F_F0F0, 1, 1, 0, 0, 0, 4});
    tbl.push_back('{0, 31, 0, 2, 0, 0, 32'h0F0F_F0F0, 0, 5});
`ifdef DBG_HALT_TIMEOUT_EN
    tbl.push_back('{0, 9, 0, 1000, 0, 0, 0, 1, T + 1});
    tbl.push_back('{1, 12, 32'hCAFE_F00D, 1000, 2, 0, 0, 1, T + 1});
    tbl.push_back('{0, 12, 0, 0, 0, 0, 32'hA500_000C, 0, 3});
`endif
    repeat (3) @(posedge clock);
    #1 reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_halt_req", halt_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    foreach (tbl[i]) run(tbl[i]);
    req_valid = 1; req_write = 1; req_addr = 6; req_wdata = 32'h5555_5555; halt_ack = 0;
    @(posedge clock); #1;
    req_valid = 0;
    @(posedge clock); #1;
    chk("mid_halt_req", halt_req, 1);
    chk("mid_busy", busy, 1);
    reset = 1;
    @(posedge clock); #1;
    chk("abort_halt_req", halt_req, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rf_we", rf_we, 0);
    reset = 0;
    halt_ack = 1;
    chk("abort_req_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("abort_no_resp", resp_valid, 0);
      chk("abort_no_we", rf_we, 0);
    end
    halt_ack = 0;
    run('{0, 6, 0, 0, 0, 0, 32'hA500_0006, 0, 3});
    run('{0, 3, 0, 1, 0, 0, 32'h2A, 0, 4});
    repeat (2) @(posedge clock);
    #1;
    chk("resp_queue_empty", exp_q.size(), 0);
    chk("write_queue_empty", wexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
